// File: rtl/pe_credit_node.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_credit_node : NoC PE with credit-gated packet injection and a credit-returning RX FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
module pe_credit_node #(
    parameter int         FLIT_W   = 20,
    parameter int         CREDITS  = 7,
    parameter int         RX_DEPTH = 8,
    parameter logic [3:0] NODE_ID  = 4'd0,
    parameter int         LEN_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [3:0]        tx_dest,
    input  logic [LEN_W-1:0]  tx_len,
    output logic              tx_busy,
    output logic [FLIT_W-1:0] dataout,
    output logic              out_valid,
    input  logic              ci,
    input  logic [FLIT_W-1:0] datain,
    input  logic              in_valid,
    input  logic              rx_ready,
    output logic              co,
    output logic [FLIT_W-7:0] read,
    output logic [15:0]       rx_pkt_cnt,
    output logic [2:0]        err
);

    localparam int                c_PAY_W    = FLIT_W - 6;
    localparam int                c_CW       = $clog2(CREDITS + 1);
    localparam int                c_AW       = $clog2(RX_DEPTH);
    localparam logic [c_CW-1:0]   c_CRED_MAX = c_CW'(CREDITS);
    localparam logic [LEN_W-1:0]  c_LEN_ONE  = LEN_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic                first_q, first_d;
    logic [3:0]          dest_q, dest_d;
    logic [c_PAY_W-1:0]  seq_q, seq_d;
    logic [c_CW-1:0]     cred_q, cred_d;
    logic [FLIT_W-1:0]   dataout_q, dataout_d;
    logic                out_valid_q, out_valid_d;
    logic                w_send;
    logic                w_cred_ovf;
    logic [1:0]          w_kind;

    // TX next-state: a flit leaves only when a credit is already held
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        first_d     = first_q;
        dest_d      = dest_q;
        seq_d       = seq_q;
        dataout_d   = dataout_q;
        out_valid_d = 1'b0;
        w_send      = 1'b0;
        w_kind      = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d = S_SEND;
                    dest_d  = tx_dest;
                    rem_d   = (tx_len == '0) ? c_LEN_ONE : tx_len;
                    first_d = 1'b1;
                end
            end
            S_SEND: begin
                if (cred_q != '0) begin
                    w_send = 1'b1;
                    if (rem_q == c_LEN_ONE)
                        w_kind = first_q ? 2'b11 : 2'b10;
                    else
                        w_kind = first_q ? 2'b01 : 2'b00;
                    dataout_d   = {w_kind, dest_q, seq_q};
                    out_valid_d = 1'b1;
                    seq_d       = seq_q + 1'b1;
                    rem_d       = rem_q - 1'b1;
                    first_d     = 1'b0;
                    if (rem_q == c_LEN_ONE)
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cred_d     = cred_q;
        w_cred_ovf = 1'b0;
        if (w_send && !ci) begin
            cred_d = cred_q - 1'b1;
        end else if (ci && !w_send) begin
            if (cred_q == c_CRED_MAX)
                w_cred_ovf = 1'b1;
            else
                cred_d = cred_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            first_q     <= 1'b0;
            dest_q      <= '0;
            seq_q       <= '0;
            cred_q      <= c_CRED_MAX;
            dataout_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            dest_q      <= dest_d;
            seq_q       <= seq_d;
            cred_q      <= cred_d;
            dataout_q   <= dataout_d;
            out_valid_q <= out_valid_d;
        end
    end

    // RX FIFO: the extra pointer bit separates full from empty
    logic [FLIT_W-1:0]   mem [RX_DEPTH];
    logic [c_AW:0]       wp_q, rp_q;
    logic                co_q;
    logic [c_PAY_W-1:0]  read_q;
    logic [15:0]         cnt_q;
    logic [2:0]          err_q;
    logic                w_empty, w_full, w_pop, w_push, w_match;
    logic [FLIT_W-1:0]   w_head;
    logic [1:0]          w_head_kind;

    assign w_empty     = (wp_q == rp_q);
    assign w_full      = (wp_q[c_AW] != rp_q[c_AW]) && (wp_q[c_AW-1:0] == rp_q[c_AW-1:0]);
    assign w_pop       = rx_ready && !w_empty;
    assign w_push      = in_valid && (!w_full || w_pop);
    assign w_head      = mem[rp_q[c_AW-1:0]];
    assign w_head_kind = w_head[FLIT_W-1:FLIT_W-2];
    assign w_match     = (w_head[FLIT_W-3:FLIT_W-6] == NODE_ID);

    always_ff @(posedge clk) begin
        if (w_push)
            mem[wp_q[c_AW-1:0]] <= datain;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            co_q   <= 1'b0;
            read_q <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
        end else begin
            if (w_push)
                wp_q <= wp_q + 1'b1;
            if (w_pop)
                rp_q <= rp_q + 1'b1;
            co_q <= w_pop;
            if (w_pop && w_match) begin
                read_q <= w_head[c_PAY_W-1:0];
                if (w_head_kind == 2'b10 || w_head_kind == 2'b11)
                    cnt_q <= cnt_q + 16'd1;
            end
            err_q <= err_q | {w_pop && !w_match, in_valid && !w_push, w_cred_ovf};
        end
    end

    assign tx_busy    = (state_q == S_SEND);
    assign dataout    = dataout_q;
    assign out_valid  = out_valid_q;
    assign co         = co_q;
    assign read       = read_q;
    assign rx_pkt_cnt = cnt_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_credit_node.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pe_credit_node : scoreboard bench with a queue-based reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pe_credit_node;

    localparam int         FW    = 20;
    localparam int         CR    = 7;
    localparam int         DEPTH = 8;
    localparam int         PW    = FW - 6;
    localparam logic [3:0] NID   = 4'd5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tx_start = 1'b0;
    logic [3:0]    tx_dest = '0;
    logic [3:0]    tx_len = '0;
    logic          tx_busy;
    logic [FW-1:0] dataout;
    logic          out_valid;
    logic          ci = 1'b0;
    logic [FW-1:0] datain = '0;
    logic          in_valid = 1'b0;
    logic          rx_ready = 1'b0;
    logic          co;
    logic [PW-1:0] read;
    logic [15:0]   rx_pkt_cnt;
    logic [2:0]    err;

    always #5 clk = ~clk;

    pe_credit_node #(
        .FLIT_W(FW), .CREDITS(CR), .RX_DEPTH(DEPTH), .NODE_ID(NID), .LEN_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_start(tx_start), .tx_dest(tx_dest), .tx_len(tx_len), .tx_busy(tx_busy),
        .dataout(dataout), .out_valid(out_valid), .ci(ci),
        .datain(datain), .in_valid(in_valid), .rx_ready(rx_ready),
        .co(co), .read(read), .rx_pkt_cnt(rx_pkt_cnt), .err(err)
    );

    typedef struct {
        bit            ov;
        bit            busy;
        bit            co;
        logic [PW-1:0] rd;
        logic [15:0]   cnt;
        logic [2:0]    err;
    } exp_t;

    exp_t          exq[$];
    logic [FW-1:0] txq[$];
    logic [FW-1:0] rxm[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit            m_busy;
    int            m_pend, m_cred, m_seq, m_sent;
    logic [2:0]    m_err;
    logic [PW-1:0] m_rd;
    logic [15:0]   m_cnt;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_pend = 0; m_cred = CR; m_seq = 0; m_sent = 0;
        m_err = '0; m_rd = '0; m_cnt = '0;
        txq.delete(); rxm.delete(); exq.delete();
    endfunction

    // Apply the rules for the coming edge to the model, queue expectations, advance one cycle
    task automatic step();
        exp_t          e;
        bit            send, pop, acc, was_busy;
        int            len;
        logic [1:0]    kind;
        logic [FW-1:0] f;
        was_busy = m_busy;
        send = m_busy && (m_cred > 0);
        if (send) begin
            m_pend--; m_sent++;
            if (m_pend == 0) m_busy = 0;
        end
        if (!was_busy && tx_start) begin
            len = (tx_len == 0) ? 1 : int'(tx_len);
            for (int i = 0; i < len; i++) begin
                if (len == 1)           kind = 2'b11;
                else if (i == 0)        kind = 2'b01;
                else if (i == len - 1)  kind = 2'b10;
                else                    kind = 2'b00;
                txq.push_back({kind, tx_dest, PW'(m_seq + i)});
            end
            m_seq += len;
            m_busy = 1; m_pend = len;
        end
        if (send && !ci) m_cred--;
        else if (ci && !send) begin
            if (m_cred == CR) m_err[0] = 1'b1;
            else m_cred++;
        end
        pop = rx_ready && (rxm.size() > 0);
        acc = in_valid && ((rxm.size() < DEPTH) || pop);
        if (pop) begin
            f = rxm.pop_front();
            if (f[FW-3:FW-6] == NID) begin
                m_rd = f[PW-1:0];
                if (f[FW-1]) m_cnt = m_cnt + 16'd1;
            end else begin
                m_err[2] = 1'b1;
            end
        end
        if (in_valid && !acc) m_err[1] = 1'b1;
        if (acc) rxm.push_back(datain);
        e = '{send, m_busy, pop, m_rd, m_cnt, m_err};
        exq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        tx_start = 0; ci = 0; in_valid = 0; rx_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        chk("rst_dataout", dataout, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_co", co, 0);
        chk("rst_read", read, 0);
        chk("rst_rx_pkt_cnt", rx_pkt_cnt, 0);
        chk("rst_err", err, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_pkt(input logic [3:0] d, input logic [3:0] l);
        tx_start = 1; tx_dest = d; tx_len = l;
        step();
        tx_start = 0;
    endtask

    task automatic push_flit(input logic [1:0] k, input logic [3:0] d, input logic [PW-1:0] p);
        in_valid = 1; datain = {k, d, p};
        step();
        in_valid = 0;
    endtask

    // Monitor: compares the DUT against the oldest queued expectation after every edge
    exp_t          mon_e;
    logic [FW-1:0] mon_f;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst && exq.size() > 0) begin
                mon_e = exq.pop_front();
                chk("out_valid", out_valid, mon_e.ov);
                chk("tx_busy", tx_busy, mon_e.busy);
                chk("co", co, mon_e.co);
                chk("read", read, mon_e.rd);
                chk("rx_pkt_cnt", rx_pkt_cnt, mon_e.cnt);
                chk("err", err, mon_e.err);
                if (out_valid) begin
                    if (txq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL dataout: unexpected flit %0h, none expected", dataout);
                    end else begin
                        mon_f = txq.pop_front();
                        chk("dataout", dataout, mon_f);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // 4-flit packet, no credit return
        send_pkt(4'd3, 4'd4);
        repeat (6) step();
        ci = 1; repeat (4) step(); ci = 0;

        // 10-flit packet: stall at 0 credits, single credit releases one flit
        send_pkt(4'd1, 4'd10);
        repeat (12) step();
        ci = 1; step(); ci = 0;
        repeat (3) step();
        ci = 1; repeat (10) step(); ci = 0;
        step();

        // RX overflow then drain
        do_reset();
        for (int i = 0; i < 9; i++) push_flit(2'b00, NID, PW'(i + 16));
        rx_ready = 1; repeat (10) step();

        // Matched head/body/tail, then misrouted single flit
        push_flit(2'b01, NID, 14'h0101);
        push_flit(2'b00, NID, 14'h0202);
        push_flit(2'b10, NID, 14'h0303);
        push_flit(2'b11, 4'd2, 14'h0404);
        repeat (3) step();
        rx_ready = 0;

        // Reset mid-packet, then a fresh packet restarts the sequence
        do_reset();
        send_pkt(4'd7, 4'd4);
        for (int i = 0; i < 10 && m_sent < 2; i++) step();
        do_reset();
        send_pkt(4'd5, 4'd3);
        repeat (4) step();
        send_pkt(4'd2, 4'd10);
        repeat (14) step();
        ci = 1; repeat (10) step(); ci = 0;

        // Randomised traffic on both directions
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tx_start = ($urandom_range(0, 3) == 0);
            tx_dest  = 4'($urandom);
            tx_len   = 4'($urandom);
            ci       = (m_cred < CR) && ($urandom_range(0, 1) == 1);
            in_valid = ($urandom_range(0, 2) != 0);
            datain   = {2'($urandom),
                        ($urandom_range(0, 7) == 0) ? 4'($urandom) : NID,
                        PW'($urandom)};
            rx_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        tx_start = 0; in_valid = 0; rx_ready = 1;
        for (int c = 0; c < 40; c++) begin
            ci = (m_cred < CR);
            step();
        end
        idle_inputs();
        step();
        @(negedge clk);
        chk("tx_flits_drained", txq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_credit_node.md
# pe_credit_node

Parametrised network-on-chip processing element that injects packets into its attached router port and drains flits delivered by that router. The transmit side is governed by a credit counter. The receive side buffers flits in a FIFO and returns one credit per consumed flit. Compared with the fixed 20-bit, 7-credit PE generation, this block generalises flit width, credit depth, RX buffer depth and node ID, and adds:

- configurable packet length and destination;
- head/body/tail framing;
- destination checking;
- sticky error reporting.

## Interface
Parameters:
- FLIT_W, 20, flit width; minimum 12.
- CREDITS, 7, downstream buffer slots; reset value of the credit counter.
- RX_DEPTH, 8, RX FIFO entries; power of two, at least 2.
- NODE_ID, 0, 4-bit ID of this node; used for destination checking.
- LEN_W, 4, width of the packet-length field.

Ports (reset rst, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- tx_start  in  1  request one packet; sampled only when tx_busy=0.
- tx_dest  in  4  destination ID; captured with tx_start.
- tx_len  in  LEN_W  flits per packet; captured with tx_start; 0 is treated as 1.
- tx_busy  out  1  high from the cycle after an accepted tx_start until the last flit is sent.
- dataout  out  FLIT_W  registered flit to the router.
- out_valid  out  1  registered; high for one cycle per flit sent.
- ci  in  1  credit return from downstream; one credit per cycle high.
- datain  in  FLIT_W  flit from the router.
- in_valid  in  1  datain is valid this cycle.
- rx_ready  in  1  local consumer accepts one flit per cycle.
- co  out  1  registered credit pulse back to the router; one per popped flit.
- read  out  FLIT_W-6  payload of the last popped flit whose destination matched.
- rx_pkt_cnt  out  16  count of packets received; wraps at 16 bits.
- err  out  3  sticky error flags: [0] credit overflow, [1] RX overflow, [2] misroute.

## Operation
Flit format:
- Bits [FLIT_W-1:FLIT_W-2] are the kind: 01 head, 00 body, 10 tail, 11 single-flit packet.
- Bits [FLIT_W-3:FLIT_W-6] are the destination.
- Bits [FLIT_W-7:0] are the payload.

TX state machine, states IDLE and SEND:
- IDLE goes to SEND when tx_start=1. At that edge tx_dest and the length are latched, and the remaining-flit counter is loaded.
- In SEND, a flit is emitted at an edge only if the credit count is greater than 0. A ci arriving in the same cycle does not enable that send.
- Kind selection: a one-flit packet is sent as 11. Otherwise the first flit is 01, the last is 10, and all others are 00.
- Payload is a free-running TX sequence counter. It increments once per emitted flit, wraps at its field width, and resets to 0.
- After the last flit is emitted the FSM returns to IDLE at that same edge.
- tx_start while busy is ignored.

Credit counter:
- Range 0..CREDITS; reset value CREDITS.
- A send without ci decrements it. ci without a send increments it. A send and ci in the same cycle leave it unchanged.
- ci when the count equals CREDITS and no send occurs: the count saturates and err[0] is set.

RX FIFO:
- A push occurs when in_valid=1.
- The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- Otherwise the flit is dropped, err[1] is set, and no credit is returned.
- A pop occurs when rx_ready=1 and the FIFO is not empty. co is high the following cycle.
- Popped flit with destination equal to NODE_ID:
  - read is updated with its payload;
  - if its kind is 10 or 11, rx_pkt_cnt increments.
- Popped flit with any other destination: err[2] is set, read is unchanged, and the credit is still returned.

err bits are cleared only by reset.

## Timing
Reset values:
- dataout 0, out_valid 0, tx_busy 0, co 0, read 0, rx_pkt_cnt 0, err 0.
- Credit counter CREDITS, FSM IDLE, FIFO empty, TX sequence counter 0.

Latencies and rates:
- tx_start at edge N gives tx_busy=1 after N and the first out_valid after edge N+1 at the earliest.
- Maximum TX throughput is one flit per cycle while credits are available.
- A flit pushed at edge N can pop at edge N+1 at the earliest. co and read update after that pop edge.

Boundary cases:
- Credits reach 0 mid-packet: the FSM holds in SEND with out_valid=0 and dataout held, and resumes on the cycle after ci.
- rst asserted mid-packet: the packet is abandoned immediately and all state returns to reset values. No partial tail is sent.
- FIFO pointers wrap modulo RX_DEPTH. Full and empty are distinguished with an extra pointer bit.

## Test plan
- Reset, then tx_start with tx_dest=3, tx_len=4, ci held 0 -> out_valid on 4 consecutive cycles; kinds 01, 00, 00, 10; payloads 0, 1, 2, 3; credits end at 3; tx_busy drops after the last flit.
- tx_len=10 with no ci -> exactly 7 flits, then a stall with tx_busy=1. One ci pulse -> exactly one more flit.
- ci and a send in the same cycle -> credit count unchanged. ci at count 7 while idle -> count stays 7 and err[0]=1.
- NODE_ID=5, rx_ready=0, 9 flits pushed -> first 8 stored, 9th dropped, err[1]=1. Then rx_ready=1 -> 8 co pulses.
- Packet with dest=5 (head, body, tail) popped -> rx_pkt_cnt=1 and read equals the tail payload. Single flit with dest=2 -> err[2]=1, co pulses, read unchanged.
- rst pulsed after the 2nd flit of a 4-flit packet -> all outputs at reset values next cycle and credit count 7. A new packet then starts with payload 0.
